// File: rtl/mmcm_seq_pkg.sv
// Shared types and sizing helpers for the MMCM reset sequencer.
package mmcm_seq_pkg;

  typedef enum logic [1:0] {RST_MMCM, WAIT_LOCK, STABLE, RUN} state_e;

  // Width needed to count up to the largest of the three interval parameters.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow, level-type signals crossing into clk.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// Drives MMCM RST through power-up, lock-timeout retry and loss-of-lock recovery,
// and produces a registered system reset released only after a stable lock.
module mmcm_reset_sequencer
  import mmcm_seq_pkg::*;
#(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int HOLD         = 1024,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             locked_in,
  input  logic             force_relock,
  output logic             mmcm_reset,
  output logic             sys_reset,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] lost_count
);

  localparam int CW = cnt_width(RST_PULSE, LOCK_TIMEOUT, HOLD);
  localparam logic [CW-1:0]    RST_LAST  = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0]    TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CNT_W-1:0] EVT_MAX   = '1;

  logic              locked_s;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]  lost_q, lost_d;
  logic              mmcm_reset_q, mmcm_reset_d;
  logic              sys_reset_q, sys_reset_d;
  logic              ready_q, ready_d;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (locked_in),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      RST_MMCM: begin
        // force_relock is deliberately ignored here so the pulse length is fixed.
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (force_relock) begin
          state_d = RST_MMCM;
          cnt_d   = '0;
        end else if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RST_MMCM;
          cnt_d   = '0;
          if (retry_q != EVT_MAX) retry_d = retry_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE: begin
        if (force_relock) begin
          state_d = RST_MMCM;
          cnt_d   = '0;
        end else if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (force_relock) begin
          state_d = RST_MMCM;
          cnt_d   = '0;
        end else if (!locked_s) begin
          state_d = RST_MMCM;
          cnt_d   = '0;
          if (lost_q != EVT_MAX) lost_d = lost_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RST_MMCM;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they switch on the same edge as the FSM.
    mmcm_reset_d = (state_d == RST_MMCM);
    sys_reset_d  = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RST_MMCM;
      cnt_q        <= '0;
      retry_q      <= '0;
      lost_q       <= '0;
      mmcm_reset_q <= 1'b1;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      mmcm_reset_q <= mmcm_reset_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
    end
  end

  assign mmcm_reset  = mmcm_reset_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule
